int_to_fp32: RTL and testbench

Converts a 32-bit integer, signed or unsigned, into an IEEE-754 single-precision value. Rounding is round-to-nearest-even.
- Sits directly upstream of the fp32 adder and supplies its operands.
- Uses a valid/ready handshake on both input and output.
- Normalises iteratively, one bit per cycle, so latency depends on the data.

---
 rtl/fp32_pkg.sv | 22 ++
 rtl/int_to_fp32_if.sv | 29 ++
 rtl/fp32_round_pack.sv | 31 +++
 rtl/int_to_fp32.sv | 100 ++++++++++
 tb/tb_int_to_fp32.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 constants and FSM state type, used by the int-to-fp32 converter and the fp32 adder.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] FP32_BIAS = 8'd127;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } conv_state_t;

    function automatic logic [31:0] fp32_pack(input logic sign,
                                              input logic [EXP_W-1:0] exp_biased,
                                              input logic [MAN_W-1:0] man);
        return {sign, exp_biased, man};
    endfunction

endpackage

// File: rtl/int_to_fp32_if.sv
// Valid/ready operand and result channels of the int-to-fp32 converter.
interface int_to_fp32_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/fp32_round_pack.sv
// Rounds a normalised 32-bit magnitude to nearest-even and packs it as fp32.
// A magnitude without its leading one is treated as zero and yields +0.0.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic             sign,
    input  logic [EXP_W-1:0] exp_unb,
    input  logic [31:0]      mag,
    output logic [31:0]      result
);

    logic             lsb;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic             carry;
    logic [MAN_W-1:0] man_rounded;
    logic [EXP_W-1:0] exp_biased;

    assign lsb      = mag[8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard & (sticky | lsb);

    // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
    assign {carry, man_rounded} = {1'b0, mag[30:8]} + {{MAN_W{1'b0}}, round_up};
    assign exp_biased = exp_unb + FP32_BIAS + {{(EXP_W-1){1'b0}}, carry};

    assign result = mag[31] ? fp32_pack(sign, exp_biased, man_rounded) : FP32_POS_ZERO;

endmodule

// File: rtl/int_to_fp32.sv
// Iterative 32-bit integer to fp32 converter: one normalisation shift per cycle,
// then a single round-and-pack cycle, with valid/ready on both sides.
module int_to_fp32
    import fp32_pkg::*;
#(
    parameter bit SIGNED = 1'b1
)
(
    input logic         clock,
    input logic         reset_n,
    int_to_fp32_if.slave bus
);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [31:0]      mag;
    logic [31:0]      mag_next;
    logic [EXP_W-1:0] exp_unb;
    logic [EXP_W-1:0] exp_next;
    logic             sign;
    logic             sign_next;
    logic [31:0]      out_data_reg;
    logic [31:0]      out_data_next;
    logic             accept_sign;
    logic [31:0]      accept_mag;
    logic [31:0]      packed_result;

    // Negating 0x80000000 leaves it unchanged, which is exactly its magnitude.
    assign accept_sign = SIGNED & bus.in_data[31];
    assign accept_mag  = accept_sign ? (~bus.in_data + 32'd1) : bus.in_data;

    fp32_round_pack u_round_pack (
        .sign    (sign),
        .exp_unb (exp_unb),
        .mag     (mag),
        .result  (packed_result)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mag          <= 32'd0;
            exp_unb      <= '0;
            sign         <= 1'b0;
            out_data_reg <= FP32_POS_ZERO;
        end else begin
            state        <= state_next;
            mag          <= mag_next;
            exp_unb      <= exp_next;
            sign         <= sign_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state;
        mag_next      = mag;
        exp_next      = exp_unb;
        sign_next     = sign;
        out_data_next = out_data_reg;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_next = accept_sign;
                    mag_next  = accept_mag;
                    exp_next  = 8'd31;
                    if (accept_mag == 32'd0) begin
                        out_data_next = FP32_POS_ZERO;
                        state_next    = DONE;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[31]) begin
                    state_next = ROUND;
                end else begin
                    mag_next = {mag[30:0], 1'b0};
                    exp_next = exp_unb - 8'd1;
                end
            end
            ROUND: begin
                out_data_next = packed_result;
                state_next    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_to_fp32.sv
// Self-checking bench for int_to_fp32: directed vector table, reset/backpressure
// sequences and a randomized stream checked against an arithmetic reference model.
module tb_int_to_fp32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    int_to_fp32_if bus_s ();
    int_to_fp32_if bus_u ();

    int_to_fp32 #(.SIGNED(1'b1)) dut_s (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    int_to_fp32 #(.SIGNED(1'b0)) dut_u (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_u)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        bit          sgn;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    vec_t vecs [11];

    // Reference: exact integer value, RNE by remainder against half an ulp.
    function automatic logic [31:0] ref_conv(input logic [31:0] d, input bit sgn);
        longint unsigned m, q, rem, half;
        int p, sh;
        bit s;
        s = sgn && d[31];
        m = s ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 33; i++) if (m >= (64'd1 << i)) p = i;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh = p - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        return {s, 8'(p + 127), q[22:0]};
    endfunction

    function automatic logic get_ov(input bit sgn);
        return sgn ? bus_s.out_valid : bus_u.out_valid;
    endfunction

    function automatic logic get_ir(input bit sgn);
        return sgn ? bus_s.in_ready : bus_u.in_ready;
    endfunction

    function automatic logic [31:0] get_od(input bit sgn);
        return sgn ? bus_s.out_data : bus_u.out_data;
    endfunction

    task automatic drive_in(input bit sgn, input logic v, input logic [31:0] d);
        if (sgn) begin
            bus_s.in_valid = v;
            bus_s.in_data  = d;
        end else begin
            bus_u.in_valid = v;
            bus_u.in_data  = d;
        end
    endtask

    task automatic drive_ready(input bit sgn, input logic r);
        if (sgn) bus_s.out_ready = r;
        else     bus_u.out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns the result and edges from accept to out_valid.
    task automatic applyStimulus(input bit sgn, input logic [31:0] d,
                                 output logic [31:0] result, output int latency);
        drive_in(sgn, 1'b1, d);
        @(posedge clock); #1;
        drive_in(sgn, 1'b0, d);
        latency = 0;
        while (!get_ov(sgn) && latency < 100) begin
            @(posedge clock); #1;
            latency++;
        end
        result = get_od(sgn);
        drive_ready(sgn, 1'b1);
        @(posedge clock); #1;
        drive_ready(sgn, 1'b0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] d;
        int lat;
        int highs;
        bit stable;
        bit ir_seen;
        logic [31:0] exp_q [$];
        int sent;
        int got;

        vecs[0]  = '{32'h0000_0001, 1'b1, 32'h3F80_0000, 33};
        vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 33};
        vecs[2]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 2};
        vecs[3]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 0};
        vecs[4]  = '{32'h0100_0001, 1'b1, 32'h4B80_0000, 9};
        vecs[5]  = '{32'h0100_0003, 1'b1, 32'h4B80_0002, 9};
        vecs[6]  = '{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 3};
        vecs[7]  = '{32'h8000_0001, 1'b1, 32'hCF00_0000, 3};
        vecs[8]  = '{32'h0000_0003, 1'b1, 32'h4040_0000, 32};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 2};
        vecs[10] = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 2};

        drive_in(1'b1, 1'b0, 32'h0);
        drive_in(1'b0, 1'b0, 32'h0);
        drive_ready(1'b1, 1'b0);
        drive_ready(1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        checkOutput("reset in_ready", {31'b0, get_ir(1'b1)}, 32'd1);
        checkOutput("reset out_valid", {31'b0, get_ov(1'b1)}, 32'd0);
        checkOutput("reset out_data", get_od(1'b1), 32'h0);
        checkOutput("reset in_ready u", {31'b0, get_ir(1'b0)}, 32'd1);

        // Reset in the middle of a long normalisation must abort it.
        drive_in(1'b1, 1'b1, 32'h1);
        @(posedge clock); #1;
        drive_in(1'b1, 1'b0, 32'h0);
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        #3 checkOutput("midreset out_valid low", {31'b0, get_ov(1'b1)}, 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        checkOutput("midreset in_ready", {31'b0, get_ir(1'b1)}, 32'd1);
        highs = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (get_ov(1'b1)) highs++;
        end
        checkOutput("midreset no result", 32'(highs), 32'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].data, res, lat);
            checkOutput($sformatf("vec%0d data %h", i, vecs[i].data), res, vecs[i].expected);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].latency));
        end

        for (int i = 0; i < 10; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            applyStimulus(1'b0, d, res, lat);
            checkOutput($sformatf("unsigned rand %h", d), res, ref_conv(d, 1'b0));
        end

        // Backpressure: result must hold while the next operand waits.
        drive_in(1'b1, 1'b1, 32'd5);
        @(posedge clock); #1;
        drive_in(1'b1, 1'b1, 32'd10);
        lat = 0;
        while (!get_ov(1'b1) && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        checkOutput("bp first latency", 32'(lat), 32'd31);
        checkOutput("bp first data", get_od(1'b1), 32'h40A0_0000);
        stable = 1'b1;
        ir_seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (get_od(1'b1) !== 32'h40A0_0000 || !get_ov(1'b1)) stable = 1'b0;
            if (get_ir(1'b1)) ir_seen = 1'b1;
        end
        checkOutput("bp data held", {31'b0, stable}, 32'd1);
        checkOutput("bp in_ready low", {31'b0, ir_seen}, 32'd0);
        drive_ready(1'b1, 1'b1);
        @(posedge clock); #1;
        drive_ready(1'b1, 1'b0);
        checkOutput("bp out_valid drop", {31'b0, get_ov(1'b1)}, 32'd0);
        checkOutput("bp in_ready back", {31'b0, get_ir(1'b1)}, 32'd1);
        @(posedge clock); #1;
        drive_in(1'b1, 1'b0, 32'h0);
        checkOutput("bp next accepted", {31'b0, get_ir(1'b1)}, 32'd0);
        lat = 0;
        while (!get_ov(1'b1) && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        checkOutput("bp second latency", 32'(lat), 32'd30);
        checkOutput("bp second data", get_od(1'b1), 32'h4120_0000);
        drive_ready(1'b1, 1'b1);
        @(posedge clock); #1;
        drive_ready(1'b1, 1'b0);

        sent = 0;
        got = 0;
        fork
            begin : producer
                int cyc;
                logic [31:0] pd;
                logic ir;
                cyc = 0;
                while (sent < 100 && cyc < 20000) begin
                    if ($urandom_range(0, 3) == 0) begin
                        drive_in(1'b1, 1'b0, 32'h0);
                        @(posedge clock); #1;
                        cyc++;
                    end else begin
                        case ($urandom_range(0, 3))
                            0:       pd = $urandom;
                            1:       pd = $urandom >> $urandom_range(0, 31);
                            2:       pd = 32'd0 - 32'($urandom_range(0, 1000));
                            default: pd = 32'h1 << $urandom_range(0, 31);
                        endcase
                        drive_in(1'b1, 1'b1, pd);
                        do begin
                            ir = get_ir(1'b1);
                            @(posedge clock); #1;
                            cyc++;
                        end while (!ir && cyc < 20000);
                        if (ir) begin
                            exp_q.push_back(ref_conv(pd, 1'b1));
                            sent++;
                        end
                        drive_in(1'b1, 1'b0, pd);
                    end
                end
                drive_in(1'b1, 1'b0, 32'h0);
            end
            begin : consumer
                int cyc;
                logic ov;
                logic r;
                logic [31:0] od;
                cyc = 0;
                while (got < 100 && cyc < 40000) begin
                    r = ($urandom_range(0, 2) != 0);
                    drive_ready(1'b1, r);
                    ov = get_ov(1'b1);
                    od = get_od(1'b1);
                    @(posedge clock); #1;
                    cyc++;
                    if (ov && r) begin
                        got++;
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("[TB] FAIL stream extra result: got %h, expected none", od);
                        end else begin
                            checkOutput($sformatf("stream result %0d", got), od, exp_q.pop_front());
                        end
                    end
                end
                drive_ready(1'b1, 1'b0);
            end
        join
        checkOutput("stream results received", 32'(got), 32'd100);
        checkOutput("stream none left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
